// File: rtl/axis_rotate_arb_pkg.sv
// axis_rot_pkg: definitions shared by the rotate-arbiter slice.
//   - tuser field layout of the rotate-control word
//   - FSM state type of the packet arbiter
//   - amt_mod(): folds a byte rotate amount into one data word
package axis_rot_pkg;

    // tuser layout; the direction bit sits at the top of the word
    localparam int unsigned AMT_LSB = 0;
    localparam int unsigned AMT_W   = 4;
    localparam int unsigned SRC_LSB = 4;
    localparam int unsigned SRC_W   = 3;

    function automatic int unsigned dir_bit(input int unsigned tuser_width);
        return tuser_width - 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    // Rotating by a whole word is a no-op, so the engine only ever sees 0..bpw-1
    function automatic logic [AMT_W-1:0] amt_mod(input logic [AMT_W-1:0] amt,
                                                 input int unsigned     bpw);
        return AMT_W'(32'(amt) % bpw);
    endfunction

endpackage

// File: rtl/axis_rotate_arb_if.sv
// axis_rotate_arb_if: AXI-Stream bundle, N lanes side by side.
//   tdata  N*DW  lane i at [i*DW +: DW]
//   tvalid N     per-lane valid
//   tready N     per-lane ready
//   tlast  N     per-lane end of packet
//   tuser  UW    sideband (driven only on the master side)
// master modport: the producer; slave modport: the consumer.
interface axis_rotate_arb_if #(
    parameter int unsigned N  = 1,
    parameter int unsigned DW = 32,
    parameter int unsigned UW = 8
) ();
    logic [N*DW-1:0] tdata;
    logic [N-1:0]    tvalid;
    logic [N-1:0]    tready;
    logic [N-1:0]    tlast;
    logic [UW-1:0]   tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rotate_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i   NUM_PORTS  request vector
//   last_i  IDX_W      index of the port granted last
//   gnt_o   NUM_PORTS  one-hot winner (0 when no request)
//   idx_o   IDX_W      winner index
//   any_o   1          at least one request
// Search starts at last_i+1 and wraps. With AXIS_ROT_ARB_PRIO_EN defined,
// port 0 wins whenever it requests; the others stay round-robin.
import axis_rot_pkg::*;

module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

`ifdef AXIS_ROT_ARB_PRIO_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        found = 1'b0;
        cand  = '0;
        if (PRIO0 && req_i[0]) begin
            gnt_o[0] = 1'b1;
            found    = 1'b1;
        end
        // i runs 1..NUM_PORTS so the last granted port is checked last
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((32'(last_i) + i) % NUM_PORTS);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/axis_rotate_arb.sv
// axis_rotate_arb: packet-level arbiter in front of the byte-rotate engine.
//   aclk, aresetn  clock, synchronous active-low reset
//   s_axis         NUM_PORTS requesting streams (slave modport)
//   m_axis         registered output stream to the engine (master modport);
//                  tuser = {dir, 0.., src[2:0], amount[3:0]}
//   cfg_amount     per-port rotate amount (4 bits each), sampled at grant
//   cfg_dir        per-port direction, 0 = left, 1 = right, sampled at grant
//   grant          one-hot granted port, 0 when idle
//   busy           high while a packet is being passed
// One port owns the datapath from grant until its tlast beat is accepted.
// Optional: AXIS_ROT_ARB_PRIO_EN gives port 0 strict priority.
import axis_rot_pkg::*;

module axis_rotate_arb #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TUSER_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axis_rotate_arb_if.slave         s_axis,
    axis_rotate_arb_if.master        m_axis,
    input  logic [NUM_PORTS*4-1:0]   cfg_amount,
    input  logic [NUM_PORTS-1:0]     cfg_dir,
    output logic [NUM_PORTS-1:0]     grant,
    output logic                     busy
);

    localparam int unsigned BPW     = DATA_WIDTH / 8;
    localparam int unsigned IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned DIR_BIT = dir_bit(TUSER_WIDTH);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       win_q;
    logic [IDX_W-1:0]       last_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [AMT_W-1:0]       amt_q;
    logic                   dir_q;
    logic [DATA_WIDTH-1:0]  m_data_q;
    logic [TUSER_WIDTH-1:0] m_user_q;
    logic                   m_valid_q;
    logic                   m_last_q;

    logic [NUM_PORTS-1:0]   arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    logic                   stage_free;
    logic                   accept;
    logic                   win_last;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [NUM_PORTS-1:0]   s_ready;
    logic [TUSER_WIDTH-1:0] user_d;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req_i  (s_axis.tvalid),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    always_comb begin
        // Output stage can take a beat if empty or being emptied this cycle
        stage_free = ~m_valid_q | m_axis.tready;
        win_last   = s_axis.tlast[win_q];
        win_data   = s_axis.tdata[win_q*DATA_WIDTH +: DATA_WIDTH];
        s_ready    = '0;
        if (state_q == PASS) begin
            s_ready[win_q] = stage_free;
        end
        accept = (state_q == PASS) & s_axis.tvalid[win_q] & stage_free;

        user_d                    = '0;
        user_d[DIR_BIT]           = dir_q;
        user_d[AMT_LSB +: AMT_W]  = amt_q;
        user_d[SRC_LSB +: SRC_W]  = SRC_W'(win_q);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            win_q     <= '0;
            last_q    <= IDX_W'(NUM_PORTS - 1);
            grant_q   <= '0;
            amt_q     <= '0;
            dir_q     <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        state_q <= PASS;
                        win_q   <= arb_idx;
                        grant_q <= arb_gnt;
                        amt_q   <= amt_mod(cfg_amount[{arb_idx, 2'b00} +: 4], BPW);
                        dir_q   <= cfg_dir[arb_idx];
                    end
                end
                PASS: begin
                    if (accept && win_last) begin
                        state_q <= IDLE;
                        last_q  <= win_q;
                        grant_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Output register drains on its own once the packet has ended
            if (accept) begin
                m_valid_q <= 1'b1;
                m_data_q  <= win_data;
                m_last_q  <= win_last;
                m_user_q  <= user_d;
            end else if (m_axis.tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign grant         = grant_q;
    assign busy          = (state_q == PASS);

endmodule

// File: tb/tb_axis_rotate_arb.sv
module tb_axis_rotate_arb;

    logic        clk;
    logic        rstn;
    logic [3:0]  s_vld;
    logic [3:0]  s_lst;
    logic [31:0] s_dat [4];
    logic        m_rdy;
    logic [15:0] cfg_amount;
    logic [3:0]  cfg_dir;
    logic [3:0]  grant;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    axis_rotate_arb_if #(.N(4), .DW(32), .UW(8)) s_if ();
    axis_rotate_arb_if #(.N(1), .DW(32), .UW(8)) m_if ();

    assign s_if.tvalid = s_vld;
    assign s_if.tlast  = s_lst;
    assign s_if.tdata  = {s_dat[3], s_dat[2], s_dat[1], s_dat[0]};
    assign s_if.tuser  = '0;
    assign m_if.tready = m_rdy;

    axis_rotate_arb #(
        .NUM_PORTS   (4),
        .DATA_WIDTH  (32),
        .TUSER_WIDTH (8)
    ) dut (
        .aclk       (clk),
        .aresetn    (rstn),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .cfg_amount (cfg_amount),
        .cfg_dir    (cfg_dir),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Beats leaving the master port, captured half a cycle before the transfer edge
    typedef struct {
        logic [31:0] d;
        logic [7:0]  u;
        logic        l;
    } beat_t;
    beat_t mq[$];

    always @(negedge clk) begin
        if (rstn && m_if.tvalid && m_if.tready)
            mq.push_back('{m_if.tdata, m_if.tuser, m_if.tlast});
    end

    typedef struct {
        bit          rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [7:0]  dat;
        logic [3:0]  egnt;
        logic [3:0]  erdy;
        logic        emv;
        logic [31:0] edat;
        logic [7:0]  eusr;
        logic        elst;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit rst, logic [3:0] vld, logic [3:0] lst, logic [7:0] dat,
                                logic [3:0] g, logic [3:0] r, logic mv,
                                logic [31:0] d, logic [7:0] u, logic l);
        vec_t v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.dat = dat;
        v.egnt = g; v.erdy = r; v.emv = mv; v.edat = d; v.eusr = u; v.elst = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    task automatic chk_beat(input string nm, input int idx, input logic [31:0] d,
                            input logic [7:0] u, input logic l);
        if (idx >= mq.size()) begin
            fail_now($sformatf("%s beat %0d missing", nm, idx));
        end else begin
            chk($sformatf("%s beat %0d data", nm, idx), mq[idx].d, d);
            chk($sformatf("%s beat %0d user", nm, idx), 32'(mq[idx].u), 32'(u));
            chk($sformatf("%s beat %0d last", nm, idx), 32'(mq[idx].l), 32'(l));
        end
    endtask

    // Called and returns at posedge+1
    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // Sends n beats from port p; data = {p, base+beat}. After beat chg_beat is
    // accepted the port's cfg_amount is changed to new_amt.
    task automatic send_pkt(input int unsigned p, input int unsigned n, input int unsigned base,
                            input int unsigned chg_beat, input logic [3:0] new_amt);
        logic acc;
        int unsigned w;
        for (int unsigned b = 0; b < n; b++) begin
            s_vld[p] = 1'b1;
            s_lst[p] = (b == n - 1);
            s_dat[p] = {8'(p), 24'(base + b)};
            acc = 1'b0;
            w = 0;
            while (!acc && w < 60) begin
                @(negedge clk);
                acc = s_if.tready[p];
                @(posedge clk); #1;
                w++;
            end
            if (!acc) begin
                fail_now($sformatf("port %0d beat %0d not accepted", p, b));
                s_vld[p] = 1'b0;
                s_lst[p] = 1'b0;
                return;
            end
            if (b == chg_beat) cfg_amount[p*4 +: 4] = new_amt;
        end
        s_vld[p] = 1'b0;
        s_lst[p] = 1'b0;
    endtask

    task automatic stall_check();
        int unsigned w;
        w = 0;
        while (mq.size() < 1 && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        if (mq.size() < 1) begin
            fail_now("stall: first beat never left master port");
            return;
        end
        // beat 0 just transferred, beat 1 now sits in the output register
        m_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d s_tready", k), 32'(s_if.tready), 32'h0);
            chk($sformatf("stall%0d grant", k), 32'(grant), 32'h2);
            chk($sformatf("stall%0d m_tvalid", k), 32'(m_if.tvalid), 32'h1);
            chk($sformatf("stall%0d m_tdata", k), m_if.tdata, 32'h01000201);
            chk($sformatf("stall%0d m_tlast", k), 32'(m_if.tlast), 32'h0);
            @(posedge clk); #1;
        end
        m_rdy = 1'b1;
    endtask

    initial begin
        logic        acc;
        int unsigned w;
        logic [3:0]  gl [8];
        logic [3:0]  gexp [6];
        int          ng;

        rstn = 1'b0;
        s_vld = '0;
        s_lst = '0;
        for (int p = 0; p < 4; p++) s_dat[p] = '0;
        m_rdy = 1'b1;
        cfg_amount = {4'h0, 4'h1, 4'h0, 4'h0};
        cfg_dir    = 4'b0100;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset s_tready", 32'(s_if.tready), 32'h0);
        chk("reset m_tvalid", 32'(m_if.tvalid), 32'h0);
        chk("reset m_tlast", 32'(m_if.tlast), 32'h0);
        chk("reset m_tdata", m_if.tdata, 32'h0);
        chk("reset m_tuser", 32'(m_if.tuser), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Port 2, 3-beat packet, amount 1 right -> tuser A1
        vecs.push_back(mk(1, 4'h4, 4'h0, 8'd1, 4'h0, 4'h0, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'h4, 4'h0, 8'd1, 4'h4, 4'h4, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'h4, 4'h0, 8'd2, 4'h4, 4'h4, 1, 32'h02000001, 8'hA1, 0));
        vecs.push_back(mk(0, 4'h4, 4'h4, 8'd3, 4'h4, 4'h4, 1, 32'h02000002, 8'hA1, 0));
        vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0, 1, 32'h02000003, 8'hA1, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0, 0, 32'h0, 8'h00, 0));
`ifndef AXIS_ROT_ARB_PRIO_EN
        // Ports 0,1,3 with 1-beat packets: 0,1,3,0,1 with an idle cycle between
        vecs.push_back(mk(1, 4'hB, 4'hB, 8'd4,  4'h0, 4'h0, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd5,  4'h1, 4'h1, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd6,  4'h0, 4'h0, 1, 32'h00000005, 8'h00, 1));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd7,  4'h2, 4'h2, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd8,  4'h0, 4'h0, 1, 32'h01000007, 8'h10, 1));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd9,  4'h8, 4'h8, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd10, 4'h0, 4'h0, 1, 32'h03000009, 8'h30, 1));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd11, 4'h1, 4'h1, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd12, 4'h0, 4'h0, 1, 32'h0000000B, 8'h00, 1));
        vecs.push_back(mk(0, 4'hB, 4'hB, 8'd13, 4'h2, 4'h2, 0, 32'h0, 8'h00, 0));
        vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0,  4'h0, 4'h0, 1, 32'h0100000D, 8'h10, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0,  4'h0, 4'h0, 0, 32'h0, 8'h00, 0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            s_vld = vecs[i].vld;
            s_lst = vecs[i].lst;
            for (int p = 0; p < 4; p++) s_dat[p] = {8'(p), 16'h0, vecs[i].dat};
            @(negedge clk);
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].egnt));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(|vecs[i].egnt));
            chk($sformatf("v%0d s_tready", i), 32'(s_if.tready), 32'(vecs[i].erdy));
            chk($sformatf("v%0d m_tvalid", i), 32'(m_if.tvalid), 32'(vecs[i].emv));
            if (vecs[i].emv) begin
                chk($sformatf("v%0d m_tdata", i), m_if.tdata, vecs[i].edat);
                chk($sformatf("v%0d m_tuser", i), 32'(m_if.tuser), 32'(vecs[i].eusr));
                chk($sformatf("v%0d m_tlast", i), 32'(m_if.tlast), 32'(vecs[i].elst));
            end
            @(posedge clk); #1;
        end

        // Amount 6 folds to 2; a mid-packet cfg change only affects the next packet
        mq.delete();
        cfg_amount[3:0] = 4'd6;
        cfg_dir[0] = 1'b0;
        send_pkt(0, 3, 'h100, 0, 4'd3);
        send_pkt(0, 1, 'h110, 99, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("cfg beat count", 32'(mq.size()), 32'd4);
        chk_beat("cfg", 0, 32'h00000100, 8'h02, 1'b0);
        chk_beat("cfg", 1, 32'h00000101, 8'h02, 1'b0);
        chk_beat("cfg", 2, 32'h00000102, 8'h02, 1'b1);
        chk_beat("cfg", 3, 32'h00000110, 8'h03, 1'b1);

        // Backpressure for 5 cycles mid-packet
        mq.delete();
        fork
            send_pkt(1, 4, 'h200, 99, 4'd0);
            stall_check();
        join
        repeat (3) @(posedge clk);
        #1;
        chk("stall beat count", 32'(mq.size()), 32'd4);
        for (int b = 0; b < 4; b++)
            chk_beat("stall", b, 32'h01000200 + 32'(b), 8'h10, (b == 3));

        // Reset during beat 2 of a 4-beat packet from port 3
        mq.delete();
        s_vld = 4'b1000;
        s_lst = 4'b0000;
        s_dat[3] = 32'h03000300;
        acc = 1'b0;
        w = 0;
        while (!acc && w < 60) begin
            @(negedge clk);
            acc = s_if.tready[3];
            @(posedge clk); #1;
            w++;
        end
        if (!acc) fail_now("rst: port 3 beat 0 not accepted");
        s_dat[3] = 32'h03000301;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        s_vld = 4'b1001;
        s_lst = 4'b1001;
        s_dat[0] = 32'h00000400;
        s_dat[3] = 32'h03000302;
        @(negedge clk);
        chk("midrst grant", 32'(grant), 32'h0);
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst s_tready", 32'(s_if.tready), 32'h0);
        chk("midrst m_tvalid", 32'(m_if.tvalid), 32'h0);
        chk("midrst m_tlast", 32'(m_if.tlast), 32'h0);
        chk("midrst m_tdata", m_if.tdata, 32'h0);
        chk("midrst m_tuser", 32'(m_if.tuser), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after rst first grant", 32'(grant), 32'h1);
        @(posedge clk); #1;
        s_vld[0] = 1'b0;
        s_lst[0] = 1'b0;
        acc = 1'b0;
        w = 0;
        while (!acc && w < 60) begin
            @(negedge clk);
            acc = s_if.tready[3];
            @(posedge clk); #1;
            w++;
        end
        if (!acc) fail_now("rst: port 3 retry not accepted");
        s_vld = '0;
        s_lst = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst beat count", 32'(mq.size()), 32'd2);
        chk_beat("midrst", 0, 32'h00000400, 8'h03, 1'b1);
        chk_beat("midrst", 1, 32'h03000302, 8'h30, 1'b1);

        // Ports 0 and 1 always requesting, 1-beat packets
`ifdef AXIS_ROT_ARB_PRIO_EN
        gexp = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
        gexp = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2};
`endif
        ng = 0;
        s_vld = 4'b0011;
        s_lst = 4'b0011;
        s_dat[0] = 32'h00000500;
        s_dat[1] = 32'h01000500;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (grant != 4'h0 && ng < 8) begin
                gl[ng] = grant;
                ng++;
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 6; k++) begin
            if (k < ng) chk($sformatf("pair grant %0d", k), 32'(gl[k]), 32'(gexp[k]));
            else fail_now($sformatf("pair grant %0d never issued", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
